// File: rtl/cmp_flag_gen.sv
// Iterative MSB-first magnitude comparator producing less/equal flags plus the carried comparison code.
// Optional build macro EARLY_EXIT_EN: finish the scan on the first differing digit instead of after all N.
module cmp_flag_gen #(
   parameter int WIDTH   = 32,
   parameter int DIGIT_W = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] src1,
   input  logic [WIDTH-1:0] src2,
   input  logic             is_signed,
   input  logic [2:0]       comp_i,
   output logic             out_valid,
   input  logic             out_ready,
   output logic             less,
   output logic             equal,
   output logic [2:0]       comp_o,
   output logic             busy,
   output logic [1:0]       dbg_state
);

   localparam int N     = WIDTH / DIGIT_W;
   localparam int IDX_W = (N > 1) ? $clog2(N) : 1;

   // Handshake: a transfer happens on a rising edge where valid and ready are both high;
   // in_ready is only high in IDLE, out_valid only in DONE, and neither side waits on the other.
   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_SCAN = 2'd1,
      S_DONE = 2'd2
   } state_t;

   state_t             state_q, state_d;
   logic [WIDTH-1:0]   a_q, a_d, b_q, b_d;
   logic [IDX_W-1:0]   idx_q, idx_d;
   logic               decided_q, decided_d;
   logic               less_q, less_d;
   logic               equal_q, equal_d;
   logic [2:0]         comp_q, comp_d;
   logic [DIGIT_W-1:0] digit_a, digit_b;

   // Operands shift left each scan cycle, so the current digit is always the top one.
   assign digit_a = a_q[WIDTH-1 -: DIGIT_W];
   assign digit_b = b_q[WIDTH-1 -: DIGIT_W];

   always_comb begin
      state_d   = state_q;
      a_d       = a_q;
      b_d       = b_q;
      idx_d     = idx_q;
      decided_d = decided_q;
      less_d    = less_q;
      equal_d   = equal_q;
      comp_d    = comp_q;
      case (state_q)
         S_IDLE: begin
            if (in_valid) begin
               a_d = src1;
               b_d = src2;
               // Flipping both sign bits maps two's-complement order onto unsigned order.
               if (is_signed) begin
                  a_d[WIDTH-1] = ~src1[WIDTH-1];
                  b_d[WIDTH-1] = ~src2[WIDTH-1];
               end
               comp_d    = comp_i;
               idx_d     = IDX_W'(N - 1);
               decided_d = 1'b0;
               state_d   = S_SCAN;
            end
         end
         S_SCAN: begin
            a_d = a_q << DIGIT_W;
            b_d = b_q << DIGIT_W;
            if (!decided_q && (digit_a != digit_b)) begin
               less_d    = (digit_a < digit_b);
               equal_d   = 1'b0;
               decided_d = 1'b1;
`ifdef EARLY_EXIT_EN
               state_d   = S_DONE;
`endif
            end
            if (idx_q == '0) begin
               if (!decided_q && (digit_a == digit_b)) begin
                  less_d  = 1'b0;
                  equal_d = 1'b1;
               end
               state_d = S_DONE;
            end else begin
               idx_d = idx_q - IDX_W'(1);
            end
         end
         S_DONE: begin
            if (out_ready) state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= S_IDLE;
         a_q       <= '0;
         b_q       <= '0;
         idx_q     <= '0;
         decided_q <= 1'b0;
         less_q    <= 1'b0;
         equal_q   <= 1'b0;
         comp_q    <= 3'b000;
      end else begin
         state_q   <= state_d;
         a_q       <= a_d;
         b_q       <= b_d;
         idx_q     <= idx_d;
         decided_q <= decided_d;
         less_q    <= less_d;
         equal_q   <= equal_d;
         comp_q    <= comp_d;
      end
   end

   assign in_ready  = (state_q == S_IDLE) && !rst;
   assign out_valid = (state_q == S_DONE);
   assign busy      = (state_q != S_IDLE);
   assign less      = less_q;
   assign equal     = equal_q;
   assign comp_o    = comp_q;
   assign dbg_state = state_q;

endmodule

// File: tb/tb_cmp_flag_gen.sv
// Directed bench for cmp_flag_gen: flags, carried code, latency, stall, reset and back-to-back cases.
module tb_cmp_flag_gen;

   logic        clk = 1'b0;
   logic        rst;
   logic        in_valid, in_ready;
   logic [31:0] src1, src2;
   logic        is_signed;
   logic [2:0]  comp_i, comp_o;
   logic        out_valid, out_ready;
   logic        less, equal, busy;
   logic [1:0]  dbg_state;

   int n_checks = 0;
   int n_errors = 0;
   int lat;

`ifdef EARLY_EXIT_EN
   localparam bit EARLY = 1'b1;
`else
   localparam bit EARLY = 1'b0;
`endif

   cmp_flag_gen #(.WIDTH(32), .DIGIT_W(4)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
      .src1(src1), .src2(src2), .is_signed(is_signed), .comp_i(comp_i),
      .out_valid(out_valid), .out_ready(out_ready), .less(less), .equal(equal),
      .comp_o(comp_o), .busy(busy), .dbg_state(dbg_state)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Drive one request; returns after the accept edge (+1 time unit).
   task automatic start_op(input logic [31:0] a, input logic [31:0] b,
                           input logic sgn, input logic [2:0] code);
      src1 = a; src2 = b; is_signed = sgn; comp_i = code; in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
   endtask

   // Counts edges after the accept edge until out_valid is seen.
   task automatic wait_done(output int cycles);
      cycles = 0;
      for (int i = 0; i < 40; i++) begin
         @(posedge clk); #1;
         cycles++;
         if (out_valid) break;
      end
      if (!out_valid) chk("timeout_out_valid", 32'(out_valid), 32'd1);
   endtask

   task automatic release_result();
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
   endtask

   initial begin
      rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
      src1 = '0; src2 = '0; is_signed = 1'b0; comp_i = 3'b000;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_out_valid", 32'(out_valid), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_in_ready", 32'(in_ready), 32'd0);
      chk("rst_flags", {30'd0, less, equal}, 32'd0);
      chk("rst_comp_o", 32'(comp_o), 32'd0);
      rst = 1'b0; #1;
      chk("idle_in_ready", 32'(in_ready), 32'd1);

      // 1: unsigned 5 vs 7, differs only in the last digit
      start_op(32'd5, 32'd7, 1'b0, 3'b000);
      chk("t1_busy", 32'(busy), 32'd1);
      wait_done(lat);
      chk("t1_lat", 32'(lat), 32'd8);
      chk("t1_flags", {30'd0, less, equal}, 32'b10);
      chk("t1_comp_o", 32'(comp_o), 32'b000);
      release_result();

      // 2: all-ones vs one, signed and unsigned
      start_op(32'hFFFFFFFF, 32'h00000001, 1'b1, 3'b001);
      wait_done(lat);
      chk("t2s_lat", 32'(lat), EARLY ? 32'd1 : 32'd8);
      chk("t2s_flags", {30'd0, less, equal}, 32'b10);
      chk("t2s_comp_o", 32'(comp_o), 32'b001);
      release_result();
      start_op(32'hFFFFFFFF, 32'h00000001, 1'b0, 3'b010);
      wait_done(lat);
      chk("t2u_lat", 32'(lat), EARLY ? 32'd1 : 32'd8);
      chk("t2u_flags", {30'd0, less, equal}, 32'b00);
      release_result();

      // 3: equal operands, both modes
      start_op(32'h12345678, 32'h12345678, 1'b0, 3'b100);
      wait_done(lat);
      chk("t3u_lat", 32'(lat), 32'd8);
      chk("t3u_flags", {30'd0, less, equal}, 32'b01);
      release_result();
      start_op(32'h12345678, 32'h12345678, 1'b1, 3'b110);
      wait_done(lat);
      chk("t3s_lat", 32'(lat), 32'd8);
      chk("t3s_flags", {30'd0, less, equal}, 32'b01);
      chk("t3s_comp_o", 32'(comp_o), 32'b110);
      release_result();

      // 4: signed min vs max, stalled by the consumer
      start_op(32'h80000000, 32'h7FFFFFFF, 1'b1, 3'b011);
      wait_done(lat);
      chk("t4_lat", 32'(lat), EARLY ? 32'd1 : 32'd8);
      for (int i = 0; i < 5; i++) begin
         chk("t4_hold_valid", 32'(out_valid), 32'd1);
         chk("t4_hold_flags", {30'd0, less, equal}, 32'b10);
         chk("t4_hold_comp_o", 32'(comp_o), 32'b011);
         chk("t4_hold_in_ready", 32'(in_ready), 32'd0);
         src1 = 32'd1; src2 = 32'd1; comp_i = 3'b111; is_signed = 1'b0;
         in_valid = (i == 2);
         @(posedge clk); #1;
         in_valid = 1'b0;
      end
      chk("t4_still_valid", 32'(out_valid), 32'd1);
      chk("t4_still_comp_o", 32'(comp_o), 32'b011);
      release_result();
      chk("t4_back_idle", 32'(in_ready), 32'd1);
      chk("t4_out_valid_low", 32'(out_valid), 32'd0);

      // 5: reset while scanning at idx=4
      start_op(32'h12345678, 32'h12345679, 1'b0, 3'b101);
      repeat (3) @(posedge clk);
      #1;
      chk("t5_scanning", 32'(busy), 32'd1);
      rst = 1'b1; #1;
      chk("t5_rst_out_valid", 32'(out_valid), 32'd0);
      chk("t5_rst_busy", 32'(busy), 32'd0);
      chk("t5_rst_flags", {30'd0, less, equal}, 32'd0);
      chk("t5_rst_comp_o", 32'(comp_o), 32'd0);
      chk("t5_rst_in_ready", 32'(in_ready), 32'd0);
      @(negedge clk);
      rst = 1'b0; #1;
      chk("t5_rel_in_ready", 32'(in_ready), 32'd1);
      @(posedge clk); #1;
      start_op(32'h10, 32'h0F, 1'b0, 3'b010);
      wait_done(lat);
      chk("t5_lat", 32'(lat), EARLY ? 32'd7 : 32'd8);
      chk("t5_flags", {30'd0, less, equal}, 32'b00);
      chk("t5_comp_o", 32'(comp_o), 32'b010);

      // 6: back-to-back with in_valid held through the release edge
      release_result();
      start_op(32'd3, 32'd3, 1'b0, 3'b001);
      wait_done(lat);
      chk("t6a_flags", {30'd0, less, equal}, 32'b01);
      src1 = 32'h20; src2 = 32'h30; is_signed = 1'b0; comp_i = 3'b111;
      in_valid = 1'b1; out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
      chk("t6_idle_gap_busy", 32'(busy), 32'd0);
      chk("t6_idle_gap_ready", 32'(in_ready), 32'd1);
      @(posedge clk); #1;
      in_valid = 1'b0;
      chk("t6_accepted", 32'(busy), 32'd1);
      wait_done(lat);
      chk("t6b_lat", 32'(lat), EARLY ? 32'd7 : 32'd8);
      chk("t6b_flags", {30'd0, less, equal}, 32'b10);
      chk("t6b_comp_o", 32'(comp_o), 32'b111);
      release_result();

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
